// File: rtl/elastic_pipeline.sv
// elastic_pipeline: N-stage valid/ready register chain carrying {data, tag, halt}.
// Optional PIPE_PERF_EN adds saturating cycle and retire counters.
module elastic_pipeline #(
   parameter int DATA_SZ = 32,
   parameter int TAG_SZ = 5,
   parameter int STAGES = 5,
   localparam int CNT_SZ = $clog2(STAGES + 1)
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [DATA_SZ-1:0]         i_data,
   input  logic [TAG_SZ-1:0]          i_tag,
   input  logic                       i_halt,
   input  logic [STAGES-1:0]          i_stall,
   input  logic [STAGES-1:0]          i_flush,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [DATA_SZ-1:0]         o_data,
   output logic [TAG_SZ-1:0]          o_tag,
   output logic                       o_halt,
   output logic [STAGES-1:0]          o_stage_valid,
   output logic [STAGES*TAG_SZ-1:0]   o_stage_tag,
   output logic [CNT_SZ-1:0]          o_occupancy,
`ifdef PIPE_PERF_EN
   output logic [31:0]                o_cycle_cnt,
   output logic [31:0]                o_retire_cnt,
`endif
   output logic                       o_halted
);

   typedef struct packed {
      logic               halt;
      logic [TAG_SZ-1:0]  tag;
      logic [DATA_SZ-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } state_t;

   state_t            state_q;
   state_t            state_d;
   entry_t            ent_q [STAGES];
   entry_t            src   [STAGES];
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] up_ok;
   logic [STAGES-1:0] take;
   logic [STAGES-1:0] leave;
   logic [STAGES-1:0] space;
   logic [STAGES-1:0] halt_v;
   logic              en;
   logic              run;
   logic              halted;
   logic              out_leave;
   logic              halt_flushed;

   assign en     = i_enable;
   assign run    = (state_q == RUN);
   assign halted = (state_q == HALTED);

   assign out_leave = v_q[STAGES-1] & en
                    & ~i_stall[STAGES-1]
                    & ~i_flush[STAGES-1]
                    & i_ready;

   // Upstream of stage 0 is the input port; elsewhere the previous stage.
   assign up_ok = {v_q[STAGES-2:0]
                   & ~i_stall[STAGES-2:0]
                   & ~i_flush[STAGES-2:0],
                   i_valid & run};

   // Space/take chain ripples from the output back to the input.
   always_comb begin
      logic lv;
      take  = '0;
      leave = '0;
      space = '0;
      lv    = out_leave;
      for (int k = STAGES - 1; k >= 0; k--) begin
         leave[k] = lv;
         space[k] = ~v_q[k] | lv;
         take[k]  = en & ~i_stall[k] & ~i_flush[k]
                  & space[k] & up_ok[k];
         lv       = take[k];
      end
   end

   assign o_ready = en & run & ~i_stall[0]
                  & ~i_flush[0] & space[0];

   // Load source per stage: input port for stage 0, predecessor otherwise.
   always_comb begin
      src[0] = {i_halt, i_tag, i_data};
      for (int k = 1; k < STAGES; k++) begin
         src[k] = ent_q[k-1];
      end
   end

   // Stage registers: flush wins, then load, then drain, else hold.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            ent_q[k] <= '0;
         end
      end else if (en) begin
         for (int k = 0; k < STAGES; k++) begin
            if (i_flush[k]) begin
               v_q[k] <= 1'b0;
            end else if (take[k]) begin
               v_q[k]   <= 1'b1;
               ent_q[k] <= src[k];
            end else if (leave[k]) begin
               v_q[k] <= 1'b0;
            end
         end
      end
   end

   // Per-stage views: halt bits, exported tags and occupancy count.
   always_comb begin
      halt_v      = '0;
      o_stage_tag = '0;
      o_occupancy = '0;
      for (int k = 0; k < STAGES; k++) begin
         halt_v[k] = ent_q[k].halt;
         o_stage_tag[k*TAG_SZ +: TAG_SZ] = ent_q[k].tag;
         o_occupancy = o_occupancy + CNT_SZ'(v_q[k]);
      end
   end

   // A flushed halt marker means the halt was on a wrong path.
   assign halt_flushed = en & (|(i_flush & v_q & halt_v));

   // Halt-drain state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Halt-drain next state; all moves need the global enable.
   always_comb begin
      state_d = state_q;
      if (en) begin
         unique case (state_q)
            RUN: begin
               if (take[0] & i_halt) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (out_leave & ent_q[STAGES-1].halt) begin
                  state_d = HALTED;
               end else if (halt_flushed) begin
                  state_d = RUN;
               end
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   assign o_stage_valid = v_q;
   assign o_halted      = halted;
   assign o_valid       = v_q[STAGES-1] & ~halted;
   assign o_data        = halted ? '0 : ent_q[STAGES-1].data;
   assign o_tag         = halted ? '0 : ent_q[STAGES-1].tag;
   assign o_halt        = ent_q[STAGES-1].halt & ~halted;

`ifdef PIPE_PERF_EN
   // Saturating activity and retire counters.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_cycle_cnt  <= '0;
         o_retire_cnt <= '0;
      end else begin
         if (en && !halted && o_cycle_cnt != '1) begin
            o_cycle_cnt <= o_cycle_cnt + 32'd1;
         end
         if (out_leave && o_retire_cnt != '1) begin
            o_retire_cnt <= o_retire_cnt + 32'd1;
         end
      end
   end
`else
   // Counters compiled out; pipeline behaviour is unchanged.
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// tb_elastic_pipeline: directed vectors for elastic_pipeline, STAGES=5.
// Expected values are hand-derived per cycle.
module tb_elastic_pipeline;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_data;
   logic [4:0]  i_tag;
   logic        i_halt;
   logic [4:0]  i_stall;
   logic [4:0]  i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic [4:0]  o_tag;
   logic        o_halt;
   logic [4:0]  o_stage_valid;
   logic [24:0] o_stage_tag;
   logic [2:0]  o_occupancy;
   logic        o_halted;
`ifdef PIPE_PERF_EN
   logic [31:0] o_cycle_cnt;
   logic [31:0] o_retire_cnt;
`endif

   int total = 0;
   int bad = 0;

   elastic_pipeline dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_data        (i_data),
      .i_tag         (i_tag),
      .i_halt        (i_halt),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_data        (o_data),
      .o_tag         (o_tag),
      .o_halt        (o_halt),
      .o_stage_valid (o_stage_valid),
      .o_stage_tag   (o_stage_tag),
      .o_occupancy   (o_occupancy),
`ifdef PIPE_PERF_EN
      .o_cycle_cnt   (o_cycle_cnt),
      .o_retire_cnt  (o_retire_cnt),
`endif
      .o_halted      (o_halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_enable = 1'b1;
      i_valid  = 1'b0;
      i_data   = '0;
      i_tag    = '0;
      i_halt   = 1'b0;
      i_stall  = '0;
      i_flush  = '0;
      i_ready  = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      i_reset = 1'b1;
      step();
      step();
      i_reset = 1'b0;
   endtask

   logic [31:0] q_data [$];
   logic [4:0]  q_tag [$];
   int          halts;
   int          nxt;
   int          acc;
   int          ret;

   initial begin
      // reset state
      idle();
      i_reset = 1'b1;
      step();
      chk("rst.valid", o_valid, 0);
      chk("rst.svalid", o_stage_valid, 0);
      chk("rst.occ", o_occupancy, 0);
      chk("rst.halted", o_halted, 0);
      chk("rst.ready", o_ready, 1);
      chk("rst.stag", o_stage_tag, 0);
      i_reset = 1'b0;
      step();

      // 1: stream 1..8, free-flowing
      do_reset();
      for (int c = 0; c < 15; c++) begin
         i_valid = (c < 8);
         i_data  = 32'(c + 1);
         i_tag   = 5'(c + 1);
         #1;
         acc = (c < 8) ? c : 8;
         ret = (c < 5) ? 0 : ((c - 5 > 8) ? 8 : c - 5);
         chk($sformatf("t1.ready%0d", c), o_ready, 1);
         chk($sformatf("t1.occ%0d", c), o_occupancy, 64'(acc - ret));
         if (c >= 5 && c <= 12) begin
            chk($sformatf("t1.valid%0d", c), o_valid, 1);
            chk($sformatf("t1.data%0d", c), o_data, 64'(c - 4));
            chk($sformatf("t1.tag%0d", c), o_tag, 64'(c - 4));
         end else begin
            chk($sformatf("t1.valid%0d", c), o_valid, 0);
         end
         step();
      end

      // 2: fill 5, consumer blocks 3 cycles
      do_reset();
      for (int c = 0; c < 14; c++) begin
         i_valid = (c < 5);
         i_data  = 32'(c + 1);
         i_tag   = 5'(c + 1);
         i_ready = (c >= 8);
         #1;
         if (c < 5) begin
            chk($sformatf("t2.ready%0d", c), o_ready, 1);
            chk($sformatf("t2.valid%0d", c), o_valid, 0);
         end else if (c < 8) begin
            chk($sformatf("t2.ready%0d", c), o_ready, 0);
            chk($sformatf("t2.occ%0d", c), o_occupancy, 5);
            chk($sformatf("t2.valid%0d", c), o_valid, 1);
            chk($sformatf("t2.data%0d", c), o_data, 1);
         end else if (c < 13) begin
            chk($sformatf("t2.valid%0d", c), o_valid, 1);
            chk($sformatf("t2.data%0d", c), o_data, 64'(c - 7));
         end else begin
            chk($sformatf("t2.valid%0d", c), o_valid, 0);
            chk($sformatf("t2.occ%0d", c), o_occupancy, 0);
         end
         step();
      end

      // 3: stall stage 2 for two cycles mid-stream
      do_reset();
      nxt = 1;
      for (int c = 0; c < 16; c++) begin
         i_valid = (nxt <= 8);
         i_data  = 32'(nxt);
         i_tag   = 5'(nxt);
         i_stall = (c == 6 || c == 7) ? 5'b00100 : 5'b00000;
         #1;
         if (c >= 5 && c <= 7) begin
            chk($sformatf("t3.valid%0d", c), o_valid, 1);
            chk($sformatf("t3.data%0d", c), o_data, 64'(c - 4));
         end else if (c >= 10 && c <= 14) begin
            chk($sformatf("t3.valid%0d", c), o_valid, 1);
            chk($sformatf("t3.data%0d", c), o_data, 64'(c - 6));
         end else begin
            chk($sformatf("t3.valid%0d", c), o_valid, 0);
         end
         if (c == 6 || c == 7) begin
            chk($sformatf("t3.ready%0d", c), o_ready, 0);
         end
         if (c == 7) begin
            chk("t3.sv7", o_stage_valid, 5'b10111);
            chk("t3.s0tag", o_stage_tag[4:0], 6);
            chk("t3.s1tag", o_stage_tag[9:5], 5);
         end
         if (c == 8) begin
            chk("t3.sv8", o_stage_valid, 5'b00111);
         end
         if (i_valid && o_ready) begin
            nxt++;
         end
         step();
      end

      // 4: flush stage 1 holding tag 7
      do_reset();
      for (int c = 0; c < 5; c++) begin
         i_valid = 1'b1;
         i_tag   = 5'(c + 4);
         i_data  = 32'(256 + c + 4);
         i_ready = 1'b0;
         step();
      end
      i_valid = 1'b0;
      #1;
      chk("t4.occ_pre", o_occupancy, 5);
      chk("t4.s1tag", o_stage_tag[9:5], 7);
      i_flush = 5'b00010;
      step();
      i_flush = '0;
      #1;
      chk("t4.occ_post", o_occupancy, 4);
      chk("t4.sv_post", o_stage_valid, 5'b11101);
      i_ready = 1'b1;
      q_data.delete();
      q_tag.delete();
      for (int c = 0; c < 10; c++) begin
         #1;
         if (o_valid) begin
            q_data.push_back(o_data);
            q_tag.push_back(o_tag);
         end
         step();
      end
      chk("t4.count", q_tag.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < q_tag.size()) begin
            chk($sformatf("t4.tag%0d", i), q_tag[i],
                64'((i < 3) ? i + 4 : 8));
            chk($sformatf("t4.data%0d", i), q_data[i],
                64'((i < 3) ? 256 + i + 4 : 264));
         end
      end

      // 5a: halt marker after 0xA drains and halts
      do_reset();
      for (int c = 0; c < 10; c++) begin
         i_valid = 1'b1;
         i_halt  = (c == 2);
         i_data  = (c == 0) ? 32'h9 : (c == 1) ? 32'hA :
                   (c == 2) ? 32'hB : 32'hC;
         i_tag   = 5'(i_data);
         #1;
         chk($sformatf("t5.ready%0d", c), o_ready, 64'(c < 3));
         if (c == 5) begin
            chk("t5.d9", o_data, 32'h9);
            chk("t5.v9", o_valid, 1);
         end
         if (c == 6) begin
            chk("t5.dA", o_data, 32'hA);
            chk("t5.hA", o_halt, 0);
         end
         if (c == 7) begin
            chk("t5.vH", o_valid, 1);
            chk("t5.hH", o_halt, 1);
            chk("t5.halted7", o_halted, 0);
         end
         if (c >= 8) begin
            chk($sformatf("t5.halted%0d", c), o_halted, 1);
            chk($sformatf("t5.valid%0d", c), o_valid, 0);
            chk($sformatf("t5.occ%0d", c), o_occupancy, 0);
            chk($sformatf("t5.data%0d", c), o_data, 0);
         end
         step();
      end

      // 5b: same flow, halt flushed in stage 2
      do_reset();
      q_data.delete();
      halts = 0;
      for (int c = 0; c < 15; c++) begin
         i_valid = (c <= 6);
         i_halt  = (c == 2);
         i_data  = (c == 0) ? 32'h9 : (c == 1) ? 32'hA :
                   (c == 2) ? 32'hB : 32'hC;
         i_tag   = 5'(i_data);
         i_flush = (c == 5) ? 5'b00100 : 5'b00000;
         #1;
         if (c >= 3 && c <= 5) begin
            chk($sformatf("t5b.ready%0d", c), o_ready, 0);
         end
         if (c == 5) begin
            chk("t5b.s2tag", o_stage_tag[14:10], 5'hB);
         end
         if (c == 6) begin
            chk("t5b.ready6", o_ready, 1);
         end
         if (o_valid) begin
            q_data.push_back(o_data);
            if (o_halt) halts++;
         end
         step();
      end
      chk("t5b.halted", o_halted, 0);
      chk("t5b.halts", halts, 0);
      chk("t5b.count", q_data.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < q_data.size()) begin
            chk($sformatf("t5b.data%0d", i), q_data[i],
                64'((i == 0) ? 9 : (i == 1) ? 10 : 12));
         end
      end

      // 6: asynchronous reset with 3 entries in flight
      do_reset();
      for (int c = 0; c < 3; c++) begin
         i_valid = 1'b1;
         i_data  = 32'(c + 1);
         i_tag   = 5'(c + 1);
         step();
      end
      i_valid = 1'b0;
      #1;
      chk("t6.occ_pre", o_occupancy, 3);
      chk("t6.sv_pre", o_stage_valid, 5'b00111);
`ifdef PIPE_PERF_EN
      chk("t6.cyc_pre", o_cycle_cnt, 3);
      chk("t6.ret_pre", o_retire_cnt, 0);
`endif
      #2;
      i_reset = 1'b1;
      #1;
      chk("t6.sv", o_stage_valid, 0);
      chk("t6.occ", o_occupancy, 0);
      chk("t6.valid", o_valid, 0);
      chk("t6.ready", o_ready, 1);
      chk("t6.halted", o_halted, 0);
`ifdef PIPE_PERF_EN
      chk("t6.cyc", o_cycle_cnt, 0);
      chk("t6.ret", o_retire_cnt, 0);
`endif
      step();
      i_reset = 1'b0;

      // 7: enable low freezes everything
      do_reset();
      for (int c = 0; c < 5; c++) begin
         i_valid  = (c < 4);
         i_data   = 32'(c + 1);
         i_tag    = 5'(c + 1);
         i_enable = !(c == 2 || c == 3);
         #1;
         if (c == 2 || c == 3) begin
            chk($sformatf("t7.ready%0d", c), o_ready, 0);
            chk($sformatf("t7.sv%0d", c), o_stage_valid, 5'b00011);
            chk($sformatf("t7.s0tag%0d", c), o_stage_tag[4:0], 2);
         end
         if (c == 4) begin
            chk("t7.sv4", o_stage_valid, 5'b00011);
            chk("t7.s1tag4", o_stage_tag[9:5], 1);
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
